apb_write_master: RTL and testbench

//  Downstream write stage of the AXI2APB bridge. Consumes one AXI write burst (address info + data beats

---
 rtl/apb_write_master.sv | 162 ++++++++++++++++
 tb/tb_apb_write_master.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_write_master.sv
// Replays one captured AXI write burst as a sequence of APB write transfers,
// generating FIXED/INCR/WRAP beat addresses and folding PSLVERR into one response.
module apb_write_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [3:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    input  logic                    dat_valid,
    output logic                    dat_ready,
    input  logic [DATA_WIDTH-1:0]   dat_data,
    input  logic [DATA_WIDTH/8-1:0] dat_strb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [1:0]              resp_code,
    output logic [ID_WIDTH-1:0]     resp_id,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic                    pslverr
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int MAX_SIZE = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, SETUP, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {B_FIXED, B_INCR, B_WRAP} mode_t;

    state_t                state;
    mode_t                 mode_q;
    mode_t                 mode_c;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [3:0]            cnt_q;
    logic [2:0]            size_q;
    logic [2:0]            size_c;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Oversized beats and unsupported burst shapes are normalised once, at acceptance.
    always_comb begin
        size_c = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;
        mode_c = B_INCR;
        if (cmd_burst == 2'b00)
            mode_c = B_FIXED;
        else if (cmd_burst == 2'b10 &&
                 (cmd_len == 4'd1 || cmd_len == 4'd3 || cmd_len == 4'd7 || cmd_len == 4'd15))
            mode_c = B_WRAP;
    end

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        incr_addr = addr_q + step;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (mode_q)
            B_FIXED: next_addr = addr_q;
            B_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= B_INCR;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            err_q      <= 1'b0;
            cmd_ready  <= 1'b0;
            dat_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_code  <= 2'b00;
            resp_id    <= '0;
            paddr      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        id_q      <= cmd_id;
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        size_q    <= size_c;
                        mode_q    <= mode_c;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        cmd_ready <= 1'b0;
                        dat_ready <= 1'b1;
                        state     <= WAIT_DATA;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (dat_valid && dat_ready) begin
                        pwdata    <= dat_data;
                        pstrb     <= dat_strb;
                        paddr     <= addr_q;
                        dat_ready <= 1'b0;
                        psel      <= 1'b1;
                        pwrite    <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // Errors never cut the burst short; they only colour the final response.
                    if (pready) begin
                        err_q   <= err_q | pslverr;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        if (cnt_q == len_q) begin
                            resp_valid <= 1'b1;
                            resp_code  <= (err_q | pslverr) ? 2'b10 : 2'b00;
                            resp_id    <= id_q;
                            state      <= RESP;
                        end else begin
                            cnt_q     <= cnt_q + 4'd1;
                            addr_q    <= next_addr;
                            dat_ready <= 1'b1;
                            state     <= WAIT_DATA;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        cmd_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_write_master.sv
// Randomized bench for apb_write_master: a data-source driver, an APB slave with
// programmable wait/error per beat, and an address/response model from burst arithmetic.
module tb_apb_write_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [IW-1:0] cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;
    logic          dat_valid, dat_ready;
    logic [DW-1:0] dat_data;
    logic [SW-1:0] dat_strb;
    logic          resp_valid, resp_ready;
    logic [1:0]    resp_code;
    logic [IW-1:0] resp_id;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready, pslverr;

    always #5 clk = ~clk;

    apb_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_strb(dat_strb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_code(resp_code), .resp_id(resp_id),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready), .pslverr(pslverr)
    );

    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; int gap; } beat_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; int cyc; } xfer_t;

    beat_t         dq[$];
    xfer_t         xq[$];
    int            runs[$];
    int            wait_tbl[16];
    bit            err_tbl[16];
    int            gap_tbl[16];
    logic [DW-1:0] exp_data[16];
    logic [SW-1:0] exp_strb[16];
    int            gap_left = 0;
    int            sbeat = 0, sacc = 0;
    int            cyc = 0, first_psel = -1;
    int            stab_err = 0, pw_err = 0;
    int            checks = 0, failures = 0;

    // Data source: holds dat_valid low for 'gap' cycles of dat_ready before each beat.
    always begin
        @(posedge clk);
        if (dat_valid && dat_ready && dq.size() > 0) begin
            dq.delete(0);
            gap_left = (dq.size() > 0) ? dq[0].gap : 0;
        end else if (dat_ready && gap_left > 0) begin
            gap_left--;
        end
        #1;
        if (gap_left == 0 && dq.size() > 0) begin
            dat_valid = 1'b1;
            dat_data  = dq[0].data;
            dat_strb  = dq[0].strb;
        end else begin
            dat_valid = 1'b0;
            dat_data  = DW'($urandom);
        end
    end

    // APB slave: beat k stalls wait_tbl[k] access cycles, errors per err_tbl[k].
    always begin
        @(posedge clk);
        #1;
        if (psel && penable) begin
            pready  = (sacc >= wait_tbl[sbeat % 16]);
            pslverr = pready ? err_tbl[sbeat % 16] : 1'($urandom);
            sacc++;
            if (pready) begin
                sacc = 0;
                sbeat++;
            end
        end else begin
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
        end
    end

    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic [SW-1:0] p_strb;
    bit            prev_stall = 0, prev_setup = 0;
    int            run = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (pwrite !== psel || (penable && !psel)) pw_err++;
            if (prev_stall && (paddr !== p_addr || pwdata !== p_data || pstrb !== p_strb ||
                               !psel || !penable)) stab_err++;
            if (prev_setup && !(psel && penable)) stab_err++;
        end
        if (psel && first_psel < 0) first_psel = cyc;
        if (psel && penable && pready) xq.push_back('{paddr, pwdata, pstrb, cyc});
        if (psel) run++;
        else if (run > 0) begin
            runs.push_back(run);
            run = 0;
        end
        prev_stall = psel && penable && !pready;
        prev_setup = psel && !penable;
        p_addr = paddr;
        p_data = pwdata;
        p_strb = pstrb;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Beat address from burst arithmetic: base of the aligned wrap window plus offset mod window.
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input int len,
                                                 input int size, input int burst, input int i);
        int            sz;
        int            bytes;
        bit            wrap;
        logic [AW-1:0] wl, base;
        sz    = (size > 2) ? 2 : size;
        bytes = 1 << sz;
        wrap  = (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
        if (burst == 0) return a;
        if (!wrap) return a + AW'(i * bytes);
        wl   = AW'((len + 1) * bytes);
        base = a - (a % wl);
        return base + ((a - base + AW'(i * bytes)) % wl);
    endfunction

    task automatic clear_tbls();
        for (int i = 0; i < 16; i++) begin
            wait_tbl[i] = 0;
            err_tbl[i]  = 0;
            gap_tbl[i]  = 0;
        end
    endtask

    task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                             input int size, input int burst, input int hold,
                             output logic [1:0] code, output logic [IW-1:0] rid,
                             output int hs_cyc, output int hold_err, output bit to);
        beat_t b;
        bit    hit;
        code = 2'bxx; rid = 'x; hs_cyc = 0; hold_err = 0; to = 1'b1;
        @(negedge clk);
        #1;
        xq.delete(); runs.delete(); dq.delete();
        sbeat = 0; sacc = 0; first_psel = -1; stab_err = 0; pw_err = 0;
        for (int i = 0; i <= len; i++) begin
            b.data = DW'($urandom); b.strb = SW'($urandom); b.gap = gap_tbl[i];
            exp_data[i] = b.data; exp_strb[i] = b.strb;
            dq.push_back(b);
        end
        gap_left = gap_tbl[0];
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr;
        cmd_len = 4'(len); cmd_size = 3'(size); cmd_burst = 2'(burst);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            hit = cmd_ready;
            hs_cyc = cyc;
            #1;
            if (hit) break;
        end
        cmd_valid = 1'b0;
        cmd_id = IW'($urandom); cmd_addr = AW'($urandom); cmd_len = 4'($urandom);
        if (!hit) return;
        hit = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) return;
        code = resp_code;
        rid  = resp_id;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_code !== code || resp_id !== rid || cmd_ready !== 1'b0)
                hold_err++;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) hold_err++;
        to = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({cmd_ready, dat_ready, resp_valid, psel, penable, pwrite} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {cmd_ready, dat_ready, resp_valid, psel, penable, pwrite});
        end
        checks++;
        if (paddr !== '0 || pwdata !== '0 || pstrb !== '0 || resp_code !== 2'b00 || resp_id !== '0) begin
            failures++;
            $display("FAIL reset_data got paddr=%h pwdata=%h pstrb=%h code=%b id=%h exp all zero",
                     paddr, pwdata, pstrb, resp_code, resp_id);
        end
        rst = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_incr();
        logic [1:0] code; logic [IW-1:0] rid, id; int hs, herr; bit to;
        clear_tbls();
        id = 4'h9;
        run_burst(id, 32'h1000, 3, 2, 1, 0, code, rid, hs, herr, to);
        checks++;
        if (to || xq.size() != 4) begin
            failures++;
            $display("FAIL incr_count got=%0d exp=4 timeout=%0d", xq.size(), to);
        end
        for (int i = 0; i < xq.size() && i < 4; i++) begin
            checks++;
            if (xq[i].addr !== 32'h1000 + 32'(4 * i) || xq[i].data !== exp_data[i] ||
                xq[i].strb !== exp_strb[i]) begin
                failures++;
                $display("FAIL incr_beat%0d got addr=%h data=%h strb=%h exp addr=%h data=%h strb=%h",
                         i, xq[i].addr, xq[i].data, xq[i].strb, 32'h1000 + 32'(4 * i),
                         exp_data[i], exp_strb[i]);
            end
            if (i > 0) begin
                checks++;
                if (xq[i].cyc - xq[i-1].cyc != 3) begin
                    failures++;
                    $display("FAIL incr_beat_cycles got=%0d exp=3", xq[i].cyc - xq[i-1].cyc);
                end
            end
        end
        checks++;
        if (code !== 2'b00 || rid !== id) begin
            failures++;
            $display("FAIL incr_resp got code=%b id=%h exp code=00 id=%h", code, rid, id);
        end
        checks++;
        if (first_psel - hs != 2) begin
            failures++;
            $display("FAIL incr_latency got=%0d exp=2", first_psel - hs);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] code; logic [IW-1:0] rid; int hs, herr; bit to;
        logic [AW-1:0] exp_a[4] = '{32'h2038, 32'h203C, 32'h2030, 32'h2034};
        clear_tbls();
        run_burst(4'h3, 32'h2038, 3, 2, 2, 0, code, rid, hs, herr, to);
        checks++;
        if (to || xq.size() != 4) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=4 timeout=%0d", xq.size(), to);
        end
        for (int i = 0; i < xq.size() && i < 4; i++) begin
            checks++;
            if (xq[i].addr !== exp_a[i]) begin
                failures++;
                $display("FAIL wrap_addr%0d got=%h exp=%h", i, xq[i].addr, exp_a[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [1:0] code; logic [IW-1:0] rid; int hs, herr; bit to;
        clear_tbls();
        wait_tbl[1] = 2;
        run_burst(4'h1, 32'h4000, 3, 2, 1, 0, code, rid, hs, herr, to);
        checks++;
        if (to || xq.size() != 4) begin
            failures++;
            $display("FAIL wait_count got=%0d exp=4 timeout=%0d", xq.size(), to);
            return;
        end
        checks++;
        if (xq[1].cyc - xq[0].cyc != 5 || xq[2].cyc - xq[1].cyc != 3) begin
            failures++;
            $display("FAIL wait_span got=%0d,%0d exp=5,3", xq[1].cyc - xq[0].cyc, xq[2].cyc - xq[1].cyc);
        end
        checks++;
        if (stab_err != 0 || pw_err != 0) begin
            failures++;
            $display("FAIL wait_stable got stab=%0d pwrite=%0d exp 0,0", stab_err, pw_err);
        end
        checks++;
        if (xq[1].addr !== 32'h4004 || xq[1].data !== exp_data[1]) begin
            failures++;
            $display("FAIL wait_beat1 got addr=%h data=%h exp addr=00004004 data=%h",
                     xq[1].addr, xq[1].data, exp_data[1]);
        end
    endtask

    task automatic test_error();
        logic [1:0] code; logic [IW-1:0] rid; int hs, herr; bit to;
        clear_tbls();
        err_tbl[2] = 1;
        run_burst(4'hC, 32'h5000, 3, 2, 1, 0, code, rid, hs, herr, to);
        checks++;
        if (to || xq.size() != 4) begin
            failures++;
            $display("FAIL err_count got=%0d exp=4 timeout=%0d", xq.size(), to);
        end
        checks++;
        if (code !== 2'b10 || rid !== 4'hC) begin
            failures++;
            $display("FAIL err_resp got code=%b id=%h exp code=10 id=c", code, rid);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] code; logic [IW-1:0] rid; int hs, herr; bit to;
        clear_tbls();
        gap_tbl[2] = 4;
        run_burst(4'h6, 32'h6000, 3, 2, 1, 3, code, rid, hs, herr, to);
        checks++;
        if (to || xq.size() != 4 || runs.size() != 4) begin
            failures++;
            $display("FAIL bp_count got xfers=%0d runs=%0d exp 4,4 timeout=%0d", xq.size(), runs.size(), to);
            return;
        end
        checks++;
        if (xq[2].cyc - xq[1].cyc != 7 || runs[2] != 2) begin
            failures++;
            $display("FAIL bp_gap got span=%0d psel_run=%0d exp 7,2", xq[2].cyc - xq[1].cyc, runs[2]);
        end
        checks++;
        if (herr != 0 || code !== 2'b00) begin
            failures++;
            $display("FAIL bp_resp_hold got errs=%0d code=%b exp 0,00", herr, code);
        end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        bit    hit;
        clear_tbls();
        wait_tbl[3] = 60;
        @(negedge clk);
        #1;
        dq.delete(); sbeat = 0; sacc = 0;
        for (int i = 0; i < 8; i++) begin
            b.data = DW'($urandom); b.strb = SW'($urandom); b.gap = 0;
            dq.push_back(b);
        end
        gap_left = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_id = 4'h5; cmd_addr = 32'h7000;
        cmd_len = 4'd7; cmd_size = 3'd2; cmd_burst = 2'b00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #2;
            if (psel && penable && !pready) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rstmid_reach_access got=0 exp=1");
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        dq.delete();
        clear_tbls();
        checks++;
        if ({psel, penable, resp_valid, cmd_ready, dat_ready} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_abort got=%b exp=00000", {psel, penable, resp_valid, cmd_ready, dat_ready});
        end
        rst = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle got cmd_ready=%b psel=%b exp 1,0", cmd_ready, psel);
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_noresp got=%b exp=0", resp_valid);
        end
    endtask

    task automatic test_random();
        logic [1:0] code, ecode; logic [IW-1:0] rid, id; int hs, herr; bit to;
        logic [AW-1:0] addr, ea;
        int len, size, burst, hold;
        for (int it = 0; it < 24; it++) begin
            clear_tbls();
            id = IW'($urandom); addr = AW'($urandom);
            len = $urandom_range(0, 15); size = $urandom_range(0, 7); burst = $urandom_range(0, 3);
            if (it % 3 == 0) begin
                burst = 2;
                len = (1 << $urandom_range(1, 4)) - 1;
            end
            hold = $urandom_range(0, 2);
            ecode = 2'b00;
            for (int i = 0; i <= len; i++) begin
                wait_tbl[i] = $urandom_range(0, 2);
                gap_tbl[i]  = $urandom_range(0, 2);
                err_tbl[i]  = ($urandom_range(0, 3) == 0);
                if (err_tbl[i]) ecode = 2'b10;
            end
            run_burst(id, addr, len, size, burst, hold, code, rid, hs, herr, to);
            checks++;
            if (to || xq.size() != len + 1 || runs.size() != len + 1) begin
                failures++;
                $display("FAIL rand%0d_count got xfers=%0d runs=%0d exp=%0d timeout=%0d",
                         it, xq.size(), runs.size(), len + 1, to);
                continue;
            end
            for (int i = 0; i <= len; i++) begin
                ea = model_addr(addr, len, size, burst, i);
                checks++;
                if (xq[i].addr !== ea || xq[i].data !== exp_data[i] || xq[i].strb !== exp_strb[i]) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d got addr=%h data=%h strb=%h exp addr=%h data=%h strb=%h",
                             it, i, xq[i].addr, xq[i].data, xq[i].strb, ea, exp_data[i], exp_strb[i]);
                end
                checks++;
                if (runs[i] != 2 + wait_tbl[i] ||
                    (i > 0 && xq[i].cyc - xq[i-1].cyc != 3 + wait_tbl[i] + gap_tbl[i])) begin
                    failures++;
                    $display("FAIL rand%0d_timing%0d got run=%0d span=%0d exp run=%0d span=%0d", it, i,
                             runs[i], (i > 0) ? xq[i].cyc - xq[i-1].cyc : 0, 2 + wait_tbl[i],
                             (i > 0) ? 3 + wait_tbl[i] + gap_tbl[i] : 0);
                end
            end
            checks++;
            if (code !== ecode || rid !== id || herr != 0 || stab_err != 0 || pw_err != 0) begin
                failures++;
                $display("FAIL rand%0d_resp got code=%b id=%h hold=%0d stab=%0d pw=%0d exp code=%b id=%h 0 0 0",
                         it, code, rid, herr, stab_err, pw_err, ecode, id);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
        cmd_size = '0; cmd_burst = '0; dat_valid = 1'b0; dat_data = '0; dat_strb = '0;
        resp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
        clear_tbls();
        test_reset();
        test_incr();
        test_wrap();
        test_wait_states();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
